// File: rtl/loader_pkg.sv
// loader_pkg -- shared definitions for the program loader.
//   state_t     : loader FSM state encoding
//   SYNC_BYTE   : byte that starts every load frame
//   ADDR_W_DEF  : default instruction-memory address width
//   DATA_W_DEF  : default instruction-memory word width
// The CSUM state exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CSUM = 3'd3,
`endif
        S_RUN  = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd6
    } state_t;

endpackage

// File: rtl/program_loader.sv
// program_loader -- receives a framed program over a byte stream, writes it
// into instruction memory, then releases the processor until it reports FINISH.
//
// Frame: SYNC(0xA5), LEN(N>0), N data bytes[, checksum = mod-256 sum of data].
// The trailing checksum byte is expected only when PROGRAM_LOADER_CHECKSUM_EN
// is defined at compile time.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET      in   synchronous, active-low reset
//   IN_DATA    in   load-stream byte
//   IN_VALID   in   IN_DATA valid
//   IN_READY   out  loader accepts a byte this cycle (low only while running)
//   FINISH     in   processor reports end of program (honoured only in RUN)
//   IMEM_ADDR  out  instruction-memory write address
//   IMEM_DATA  out  instruction-memory write data
//   IMEM_WE    out  write strobe, one cycle per data byte
//   CPU_RESET  out  holds the processor in reset except while running
//   DONE       out  program ran to FINISH
//   ERROR      out  malformed or corrupt load
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              FINISH,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [DATA_W-1:0] IMEM_DATA,
    output logic              IMEM_WE,
    output logic              CPU_RESET,
    output logic              DONE,
    output logic              ERROR
);

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic       is_sync;
    logic       last_byte;
    logic [7:0] len;
    logic [7:0] count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
`endif

    // The only non-ready state is RUN, so acceptance is derived from the
    // state directly rather than from IN_READY to keep the logic acyclic.
    assign accept    = IN_VALID && (state != S_RUN);
    assign is_sync   = (IN_DATA == SYNC_BYTE);
    assign last_byte = (count == len - 8'd1);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b1;
        CPU_RESET = 1'b1;
        DONE      = 1'b0;
        ERROR     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_sync) state_nxt = S_LEN;
            end
            S_HALT: begin
                DONE = 1'b1;
                if (accept && is_sync) state_nxt = S_LEN;
            end
            S_ERR: begin
                ERROR = 1'b1;
                if (accept && is_sync) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (accept) state_nxt = (IN_DATA == 8'd0) ? S_ERR : S_DATA;
            end
            S_DATA: begin
                if (accept && last_byte) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_RUN;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                // sum already covers all N data bytes when the checksum arrives
                if (accept) state_nxt = (IN_DATA == sum) ? S_RUN : S_ERR;
            end
`endif
            S_RUN: begin
                IN_READY  = 1'b0;
                CPU_RESET = 1'b0;
                if (FINISH) state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte counter, length latch, checksum accumulator and the registered
    // memory write port (write appears the cycle after the byte is accepted).
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            IMEM_WE   <= 1'b0;
            IMEM_ADDR <= '0;
            IMEM_DATA <= '0;
            count     <= 8'd0;
            len       <= 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum       <= 8'd0;
`endif
        end else begin
            IMEM_WE <= 1'b0;
            case (state)
                S_IDLE, S_HALT, S_ERR: begin
                    if (accept && is_sync) begin
                        count <= 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum   <= 8'd0;
`endif
                    end
                end
                S_LEN: begin
                    if (accept) len <= IN_DATA;
                end
                S_DATA: begin
                    if (accept) begin
                        IMEM_WE   <= 1'b1;
                        IMEM_ADDR <= ADDR_W'(count);
                        IMEM_DATA <= DATA_W'(IN_DATA);
                        count     <= count + 8'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum       <= sum + IN_DATA;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader -- directed bench for program_loader. Expected memory
// writes are queued as bytes are sent and checked as IMEM_WE pulses appear.
// Behaviour follows PROGRAM_LOADER_CHECKSUM_EN when defined for the build.
module tb_program_loader;

    logic       CLK;
    logic       RESET;
    logic [7:0] IN_DATA;
    logic       IN_VALID;
    logic       IN_READY;
    logic       FINISH;
    logic [7:0] IMEM_ADDR;
    logic [7:0] IMEM_DATA;
    logic       IMEM_WE;
    logic       CPU_RESET;
    logic       DONE;
    logic       ERROR;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    program_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_DATA   (IN_DATA),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .FINISH    (FINISH),
        .IMEM_ADDR (IMEM_ADDR),
        .IMEM_DATA (IMEM_DATA),
        .IMEM_WE   (IMEM_WE),
        .CPU_RESET (CPU_RESET),
        .DONE      (DONE),
        .ERROR     (ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte from a negedge and hold it until a rising edge takes it.
    task automatic send_byte(input logic [7:0] b);
        int  n  = 0;
        bit  ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge CLK);
            IN_DATA  = b;
            IN_VALID = 1'b1;
            if (IN_READY) begin
                @(posedge CLK);
                ok = 1'b1;
            end
            n++;
        end
        #1;
        IN_VALID = 1'b0;
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL send_timeout: byte=%0h accepted=0 required=1", b);
        end
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic pulse_finish();
        @(negedge CLK);
        FINISH = 1'b1;
        @(posedge CLK);
        #1;
        FINISH = 1'b0;
    endtask

    // Write monitor: every IMEM_WE pulse must match the next queued write.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge CLK);
            if (IMEM_WE === 1'b1) begin
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL unexpected_write: addr=%0h data=%0h required=no write", IMEM_ADDR, IMEM_DATA);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("imem_addr", {24'd0, IMEM_ADDR}, {24'd0, e[15:8]});
                    chk("imem_data", {24'd0, IMEM_DATA}, {24'd0, e[7:0]});
                end
            end
        end
    end

    initial begin
        RESET    = 1'b0;
        IN_DATA  = 8'h00;
        IN_VALID = 1'b0;
        FINISH   = 1'b0;
        repeat (3) @(posedge CLK);

        // Reset state
        @(negedge CLK);
        chk("rst_cpu_reset", {31'd0, CPU_RESET}, 32'd1);
        chk("rst_we",        {31'd0, IMEM_WE},   32'd0);
        chk("rst_addr",      {24'd0, IMEM_ADDR}, 32'd0);
        chk("rst_data",      {24'd0, IMEM_DATA}, 32'd0);
        chk("rst_done",      {31'd0, DONE},      32'd0);
        chk("rst_error",     {31'd0, ERROR},     32'd0);
        chk("rst_ready",     {31'd0, IN_READY},  32'd1);
        RESET = 1'b1;

        // Basic three-byte load, run, hold IN_VALID during RUN, finish
        push_wr(8'h00, 8'h11);
        push_wr(8'h01, 8'h22);
        push_wr(8'h02, 8'h33);
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h66);
`endif
        @(negedge CLK);
        chk("run_cpu_reset", {31'd0, CPU_RESET}, 32'd0);
        IN_DATA  = 8'hA5;
        IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("run_ready",     {31'd0, IN_READY},  32'd0);
            chk("run_hold_cpu",  {31'd0, CPU_RESET}, 32'd0);
        end
        IN_VALID = 1'b0;
        pulse_finish();
        @(negedge CLK);
        chk("halt_done",      {31'd0, DONE},      32'd1);
        chk("halt_cpu_reset", {31'd0, CPU_RESET}, 32'd1);
        chk("halt_ready",     {31'd0, IN_READY},  32'd1);
        pulse_finish();
        @(negedge CLK);
        chk("halt_finish_ignored", {31'd0, DONE}, 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Bad checksum, then a good single-byte load
        push_wr(8'h00, 8'h10);
        push_wr(8'h01, 8'h20);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h00);
        repeat (2) @(negedge CLK);
        chk("csum_error",     {31'd0, ERROR},     32'd1);
        chk("csum_cpu_reset", {31'd0, CPU_RESET}, 32'd1);
        push_wr(8'h00, 8'h07);
        send_byte(8'hA5);
        @(negedge CLK);
        chk("sync_clears_error", {31'd0, ERROR}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h07);
        send_byte(8'h07);
`else
        push_wr(8'h00, 8'h07);
        send_byte(8'hA5);
        @(negedge CLK);
        chk("sync_clears_done", {31'd0, DONE}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h07);
`endif
        @(negedge CLK);
        chk("run2_cpu_reset", {31'd0, CPU_RESET}, 32'd0);
        chk("run2_error",     {31'd0, ERROR},     32'd0);
        pulse_finish();

        // Zero length goes to ERR with no writes
        send_byte(8'hA5);
        send_byte(8'h00);
        @(negedge CLK);
        chk("len0_error",     {31'd0, ERROR},     32'd1);
        chk("len0_cpu_reset", {31'd0, CPU_RESET}, 32'd1);

        // Garbage before sync is discarded
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        @(negedge CLK);
        chk("garbage_error_held", {31'd0, ERROR}, 32'd1);
        push_wr(8'h00, 8'hAB);
        push_wr(8'h01, 8'hCD);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAB);
        send_byte(8'hCD);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h78);
`endif
        @(negedge CLK);
        chk("garbage_run",   {31'd0, CPU_RESET}, 32'd0);
        chk("garbage_error", {31'd0, ERROR},     32'd0);
        pulse_finish();

        // Reset after two of four data bytes
        push_wr(8'h00, 8'h01);
        push_wr(8'h01, 8'h02);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("midrst_we",        {31'd0, IMEM_WE},   32'd0);
        chk("midrst_cpu_reset", {31'd0, CPU_RESET}, 32'd1);
        chk("midrst_addr",      {24'd0, IMEM_ADDR}, 32'd0);
        chk("midrst_done",      {31'd0, DONE},      32'd0);
        RESET = 1'b1;
        send_byte(8'h03);
        send_byte(8'h04);
        repeat (3) @(negedge CLK);
        chk("midrst_idle_cpu_reset", {31'd0, CPU_RESET}, 32'd1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory address width; the length byte limits programs to 255 bytes.
REQ-002 SHALL have parameter DATA_W, default 8, meaning instruction-memory word width, equal to the stream byte width.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes occur on the rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port IN_DATA  input  8  load-stream byte.
REQ-006 SHALL have port IN_VALID  input  1  IN_DATA valid.
REQ-007 SHALL have port IN_READY  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port FINISH  input  1  processor control unit reports program end.
REQ-009 SHALL have port IMEM_ADDR  output  ADDR_W  instruction-memory write address.
REQ-010 SHALL have port IMEM_DATA  output  DATA_W  instruction-memory write data.
REQ-011 SHALL have port IMEM_WE  output  1  instruction-memory write strobe, one cycle per byte.
REQ-012 SHALL have port CPU_RESET  output  1  active-high hold of the processor control unit.
REQ-013 SHALL have port DONE  output  1  program ran to FINISH.
REQ-014 SHALL have port ERROR  output  1  malformed or corrupt load.

Function
REQ-015 SHALL implement states IDLE, LEN, DATA, CSUM, RUN, HALT, ERR.
REQ-016 SHALL accept a byte only on a rising edge where IN_VALID=1 and IN_READY=1.
REQ-017 SHALL drive IN_READY=1 in IDLE, LEN, DATA, CSUM, HALT and ERR, and IN_READY=0 in RUN.
REQ-018 SHALL, in IDLE, HALT or ERR, discard accepted bytes other than sync byte 0xA5; an accepted 0xA5 SHALL go to LEN and clear DONE, ERROR, byte count and checksum.
REQ-019 SHALL, in LEN, latch the accepted byte as length N; N=0 -> ERR, else -> DATA.
REQ-020 SHALL, for the k-th accepted DATA byte (k=0..N-1), drive IMEM_ADDR=k, IMEM_DATA=byte and IMEM_WE=1 in the cycle after acceptance; IMEM_WE=0 at all other times.
REQ-021 SHALL, on acceptance of byte N-1, go to CSUM when checksum is enabled, else to RUN.
REQ-022 SHALL, in CSUM, compare the accepted byte with the mod-256 sum of the N data bytes; match -> RUN, mismatch -> ERR.
REQ-023 SHALL drive CPU_RESET=0 only in RUN, and 1 in every other state, so no instruction fetch overlaps a write.
REQ-024 SHALL ignore FINISH outside RUN; FINISH=1 sampled in RUN SHALL go to HALT with DONE=1 from the next cycle.
REQ-025 SHALL leave RUN only on FINISH or on reset.
REQ-026 SHALL hold ERROR=1 in ERR until a new sync byte or reset.

Reset
REQ-027 SHALL, on RESET=0 at a rising edge, enter IDLE with CPU_RESET=1, IMEM_WE=0, IMEM_ADDR=0, IMEM_DATA=0, DONE=0, ERROR=0, count=0, sum=0.
REQ-028 SHALL, on reset mid-load, abandon the load with no further IMEM_WE pulses; already-written words are not cleared.

Configuration
REQ-029 SHALL compile the checksum check, the CSUM state and the sum accumulator only when macro PROGRAM_LOADER_CHECKSUM_EN is defined; without it, DATA goes directly to RUN and no trailing byte is expected.

Structure
REQ-030 SHALL place the state encoding, sync byte 0xA5 and default widths in shared package loader_pkg.
REQ-031 SHALL use no sub-module; the counter and checksum accumulator are inline.

Verification
REQ-032 SHALL cover: stream A5,03,11,22,33,66 -> writes 0:11, 1:22, 2:33; CPU_RESET falls; FINISH pulse -> DONE=1, CPU_RESET=1.
REQ-033 SHALL cover: stream A5,02,10,20,00 with checksum enabled -> ERROR=1, CPU_RESET stays 1; then A5,01,07,07 -> ERROR=0, RUN.
REQ-034 SHALL cover: stream A5,00 -> ERR with no IMEM_WE pulse.
REQ-035 SHALL cover: garbage 00,FF,5A before A5 -> bytes ignored, load proceeds normally.
REQ-036 SHALL cover: RESET=0 after 2 of 4 data bytes -> IDLE, IMEM_WE=0 next cycle, CPU_RESET=1.
REQ-037 SHALL cover: IN_VALID held 1 during RUN -> IN_READY=0 and no bytes consumed until HALT.
